// File: rtl/i2c_config_sequencer.sv
// I2C write-only configuration sequencer: sends each CONFIG_DATA word to DEV_ADDR as a 3-byte frame.
// Optional per-word NACK retry is compiled in when I2C_CFG_RETRY_EN is defined.
module i2c_config_sequencer #(
  parameter int          NUM_WORDS = 10,
  parameter logic [6:0]  DEV_ADDR  = 7'b0011010,
  parameter int          CLK_DIV   = 32,
  parameter int          MAX_RETRY = 3,
  parameter logic [15:0] CONFIG_DATA [NUM_WORDS] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h08F8, 16'h0A06, 16'h0C00, 16'h0E01, 16'h12FF},
  localparam int         IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_scl,
  inout  wire              io_sda,
  output logic             o_busy,
  output logic             o_finished,
  output logic             o_error,
  output logic [IDX_W-1:0] o_index
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  // Out-of-range parameters stop elaboration.
  if (CLK_DIV < 2 || NUM_WORDS < 1 || NUM_WORDS > 64 || MAX_RETRY < 0) begin : g_param_check
    $error("i2c_config_sequencer: illegal parameter setting");
  end

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, DONE, ERR} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             nack_q, nack_d;
  logic             ack_smp_q, ack_smp_d;
  logic             scl_q, scl_d;
  logic             sda_low_q, sda_low_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             err_q, err_d;
  logic [7:0]       tx_byte;
  logic             sda_in;

`ifdef I2C_CFG_RETRY_EN
  localparam int               RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  assign io_sda     = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in     = io_sda;
  assign o_scl      = scl_q;
  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_error    = err_q;
  assign o_index    = idx_q;

  // Bus levels for a given state and quarter, returned as {scl, sda_pull_low}.
  function automatic logic [1:0] bus_drive(state_e st, logic [1:0] q, logic b);
    logic [1:0] r;
    r = 2'b10;
    case (st)
      START:   r = (q == 2'd3) ? 2'b01 : {1'b1, q[1]};
      BIT:     r = {q[1], ~b};
      ACK:     r = {q[1], 1'b0};
      STOP:    r = {q[1], ~(q == 2'd3)};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    nack_d    = nack_q;
    ack_smp_d = ack_smp_q;
    busy_d    = busy_q;
    fin_d     = fin_q;
    err_d     = err_q;
`ifdef I2C_CFG_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_d   = START;
          div_d     = '0;
          qtr_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
          idx_d     = '0;
          nack_d    = 1'b0;
          ack_smp_d = 1'b0;
          busy_d    = 1'b1;
          fin_d     = 1'b0;
          err_d     = 1'b0;
`ifdef I2C_CFG_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      default: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          qtr_d = qtr_q + 2'd1;
          if (state_q == ACK && qtr_q == 2'd2) ack_smp_d = sda_in;
          if (qtr_q == 2'd3) begin
            case (state_q)
              START: begin
                state_d = BIT;
                bit_d   = 3'd7;
                byte_d  = 2'd0;
              end
              BIT: begin
                if (bit_q == 3'd0) state_d = ACK;
                else               bit_d   = bit_q - 3'd1;
              end
              ACK: begin
                if (ack_smp_q || byte_q == 2'd2) begin
                  state_d = STOP;
                  nack_d  = ack_smp_q;
                end else begin
                  state_d = BIT;
                  byte_d  = byte_q + 2'd1;
                  bit_d   = 3'd7;
                end
              end
              STOP: state_d = GAP;
              GAP: begin
                if (nack_q) begin
`ifdef I2C_CFG_RETRY_EN
                  if (retry_q < RTY_MAX) begin
                    state_d = START;
                    retry_d = retry_q + 1'b1;
                  end else begin
                    state_d = ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                  end
`else
                  state_d = ERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
`endif
                end else if (idx_q == IDX_LAST) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  fin_d   = 1'b1;
                end else begin
                  state_d = START;
                  idx_d   = idx_q + 1'b1;
`ifdef I2C_CFG_RETRY_EN
                  retry_d = '0;
`endif
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    tx_byte = 8'h00;
    case (byte_d)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = CONFIG_DATA[idx_d][15:8];
      default: tx_byte = CONFIG_DATA[idx_d][7:0];
    endcase
    {scl_d, sda_low_d} = bus_drive(state_d, qtr_d, tx_byte[bit_d]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      nack_q    <= 1'b0;
      ack_smp_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      nack_q    <= nack_d;
      ack_smp_q <= ack_smp_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
      err_q     <= err_d;
`ifdef I2C_CFG_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 The block SHALL have a parameter NUM_WORDS, default 10, giving the number of configuration words sent per sequence (1..64).
REQ-002 The block SHALL have a parameter DEV_ADDR, default 7'b0011010, giving the 7-bit target address used for every write.
REQ-003 The block SHALL have a parameter CLK_DIV, default 32, giving i_clk cycles per quarter SCL period (>=2).
REQ-004 The block SHALL have a parameter MAX_RETRY, default 3, giving the re-send attempts allowed per word after a NACK.
REQ-005 The block SHALL have a parameter CONFIG_DATA, a NUM_WORDS-entry array of 16-bit words {reg byte, data byte}, with index 0 sent first.
REQ-006 The block SHALL have the port i_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have the port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have the port i_start, input, 1 bit: a one-cycle pulse that starts a sequence.
REQ-009 The block SHALL have the port o_scl, output, 1 bit: I2C clock, driven push-pull.
REQ-010 The block SHALL have the port io_sda, inout, 1 bit: I2C data, open-drain (drives 0 or Z, never 1).
REQ-011 The block SHALL have the port o_busy, output, 1 bit: high while a sequence is in progress.
REQ-012 The block SHALL have the port o_finished, output, 1 bit: sticky; all words were ACKed.
REQ-013 The block SHALL have the port o_error, output, 1 bit: sticky; a word failed after its retries ran out.
REQ-014 The block SHALL have the port o_index, output, $clog2(NUM_WORDS) bits (minimum 1): index of the current or failing word.

Function
REQ-015 The bus SHALL be timed by a quarter-tick counter; each bit period SHALL be 4 quarters: q0,q1 with SCL low, q2,q3 with SCL high.
REQ-016 SDA SHALL change only at the start of q0, and the slave ACK SHALL be sampled at the start of q3.
REQ-017 The state machine SHALL have the states IDLE, START, BIT, ACK, STOP, GAP, DONE and ERR.
REQ-018 In IDLE, DONE or ERR, an i_start pulse SHALL clear o_finished, o_error and o_index, set o_busy and enter START the next cycle.
REQ-019 While o_busy is high, i_start SHALL be ignored.
REQ-020 The START state SHALL last 4 quarters, with SDA pulled low while SCL is high in q2, and SCL then driven low.
REQ-021 Each word frame SHALL be 3 bytes, MSB first: {DEV_ADDR,1'b0}, then CONFIG_DATA[i][15:8], then CONFIG_DATA[i][7:0].
REQ-022 After every byte, the block SHALL release SDA for one bit period (the ACK state) and sample it; 0 is ACK, 1 is NACK.
REQ-023 On a NACK, the block SHALL abandon the remaining bytes of the word and go to STOP.
REQ-024 The STOP state SHALL last 4 quarters, with SDA pulled low in q0/q1 and released while SCL is high in q3.
REQ-025 The GAP state SHALL hold the bus idle (SCL=1, SDA released) for 4 quarters.
REQ-026 After GAP, the next word SHALL be selected: the same index on a retry; otherwise index+1.
REQ-027 After the last word is ACKed and GAP completes, the block SHALL enter DONE, set o_finished=1 and clear o_busy in the same cycle.
REQ-028 A frame with CLK_DIV=c and all ACKs SHALL take exactly 120*c i_clk cycles (START 4c, 27 bits 108c, STOP 4c, GAP 4c).
REQ-029 o_index SHALL hold the index of the word in flight, and in ERR SHALL hold the failing index.
REQ-030 The retry counter SHALL reset to 0 each time a new word index begins.

Reset
REQ-031 Asserting i_rst_n=0 SHALL, asynchronously and at any point including mid-frame, force: state IDLE, o_scl=1, io_sda=Z, o_busy=0, o_finished=0, o_error=0, o_index=0, and all counters 0.
REQ-032 After reset is released, the block SHALL stay in IDLE until an i_start pulse arrives.

Configuration
REQ-033 When I2C_CFG_RETRY_EN is defined, a NACKed word SHALL be re-sent after STOP+GAP, up to MAX_RETRY times, and the block SHALL enter ERR with o_error=1 only after the (MAX_RETRY+1)th NACK.
REQ-034 When I2C_CFG_RETRY_EN is undefined, the first NACK SHALL lead to STOP, then GAP, then ERR with o_error=1, and the retry counter logic SHALL be absent.

Verification
REQ-035 NUM_WORDS=10, CLK_DIV=4, slave model always ACKs, i_start pulse -> 10 frames; o_finished=1 and o_busy=0 exactly 4800 cycles after start acceptance; decoded bytes match CONFIG_DATA and 0x34.
REQ-036 Retry enabled, MAX_RETRY=3, slave NACKs word 2 twice then ACKs -> word 2 is sent 3 times; o_finished=1; o_error=0.
REQ-037 Retry enabled, slave always NACKs word 5 -> 4 attempts at word 5; o_error=1; o_index=5; o_finished=0; words 6..9 are never sent.
REQ-038 Retry disabled, slave NACKs the address byte of word 0 -> a 1-byte frame, then STOP+GAP; o_error=1; o_index=0.
REQ-039 i_rst_n pulsed low during bit 13 of word 4 -> in the same cycle o_scl=1, io_sda=Z, all outputs 0; a following i_start restarts at word 0.
REQ-040 A second i_start while busy is ignored; an i_start in DONE clears o_finished and re-sends all 10 words.
